// File: rtl/rpn_eval_core.sv
// rpn_eval_core: postfix (RPN) expression evaluator.
// Consumes operand/operator tokens over valid/ready and evaluates them on an
// internal operand stack. Division uses a restoring divider, one quotient
// bit per cycle. The first error of an expression is latched. Remaining tokens
// are then flushed up to tok_last, and one result with error flags is returned
// per expression.
module rpn_eval_core #(
   parameter int DATA_W      = 16,
   parameter int STACK_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tok_valid,
   output logic              tok_ready,
   input  logic              tok_is_op,
   input  logic [DATA_W-1:0] tok_data,
   input  logic              tok_last,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [3:0]        res_err
);

   localparam int IDXW = $clog2(STACK_DEPTH);
   localparam int SPW  = IDXW + 1;
   localparam int CNTW = $clog2(DATA_W);
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
   localparam logic [SPW-1:0] SP_TWO  = SPW'(2);

   typedef enum logic [1:0] {ACCEPT, DIV, FLUSH, RESULT} state_t;

   state_t             state_q, state_d;
   logic [SPW-1:0]     sp_q, sp_d;
   logic [3:0]         err_q, err_d;
   logic [DATA_W-1:0]  res_data_q, res_data_d;
   logic               last_q, last_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]  quot_q, quot_d;
   logic [DATA_W-1:0]  rem_q, rem_d;
   logic [DATA_W-1:0]  dvsr_q, dvsr_d;
   logic [DATA_W-1:0]  stack_q [STACK_DEPTH];
   logic [DATA_W-1:0]  stack_d [STACK_DEPTH];

   logic               xfer;
   logic [IDXW-1:0]    top_idx, nxt_idx, push_idx;
   logic [DATA_W-1:0]  opa, opb, alu_res;
   logic [DATA_W:0]    div_shift, div_diff;
   logic               div_ge;
   logic [DATA_W-1:0]  rem_step, quot_step;

   // Reset forces both handshakes low even before the first reset edge.
   assign tok_ready = !rst && ((state_q == ACCEPT) || (state_q == FLUSH));
   assign res_valid = !rst && (state_q == RESULT);
   assign res_data  = res_data_q;
   assign res_err   = err_q;

   assign xfer     = tok_valid && tok_ready;
   assign top_idx  = IDXW'(sp_q - SP_ONE);
   assign nxt_idx  = IDXW'(sp_q - SP_TWO);
   assign push_idx = IDXW'(sp_q);
   assign opa      = stack_q[nxt_idx];
   assign opb      = stack_q[top_idx];

   // Restoring divider step: shift in the next dividend bit, subtract if it fits.
   // The remainder stays below the divisor, so the borrow bit alone decides.
   assign div_shift = {rem_q, quot_q[DATA_W-1]};
   assign div_diff  = div_shift - {1'b0, dvsr_q};
   assign div_ge    = ~div_diff[DATA_W];
   assign rem_step  = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
   assign quot_step = {quot_q[DATA_W-2:0], div_ge};

   // Single-cycle operators, all modulo 2^DATA_W.
   always_comb begin
      alu_res = '0;
      case (tok_data[1:0])
         2'b00:   alu_res = opa + opb;
         2'b01:   alu_res = opa - opb;
         default: alu_res = opa * opb;
      endcase
   end

   // Next-state, stack update and result/error capture.
   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      err_d      = err_q;
      res_data_d = res_data_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      dvsr_d     = dvsr_q;
      stack_d    = stack_q;
      unique case (state_q)
         ACCEPT: begin
            if (xfer) begin
               if (!tok_is_op) begin
                  if (sp_q == SP_FULL) begin
                     err_d      = 4'b0001;
                     res_data_d = '0;
                     state_d    = tok_last ? RESULT : FLUSH;
                  end else begin
                     stack_d[push_idx] = tok_data;
                     sp_d              = sp_q + SP_ONE;
                     if (tok_last) begin
                        state_d = RESULT;
                        if (sp_q == '0) begin
                           res_data_d = tok_data;
                        end else begin
                           res_data_d = '0;
                           err_d[3]   = 1'b1;
                        end
                     end
                  end
               end else if (sp_q < SP_TWO) begin
                  err_d      = 4'b0010;
                  res_data_d = '0;
                  state_d    = tok_last ? RESULT : FLUSH;
               end else if (tok_data[1:0] == 2'b11) begin
                  if (opb == '0) begin
                     err_d      = 4'b0100;
                     res_data_d = '0;
                     state_d    = tok_last ? RESULT : FLUSH;
                  end else begin
                     rem_d   = '0;
                     quot_d  = opa;
                     dvsr_d  = opb;
                     cnt_d   = CNTW'(DATA_W - 1);
                     sp_d    = sp_q - SP_ONE;
                     last_d  = tok_last;
                     state_d = DIV;
                  end
               end else begin
                  stack_d[nxt_idx] = alu_res;
                  sp_d             = sp_q - SP_ONE;
                  if (tok_last) begin
                     state_d = RESULT;
                     if (sp_q == SP_TWO) begin
                        res_data_d = alu_res;
                     end else begin
                        res_data_d = '0;
                        err_d[3]   = 1'b1;
                     end
                  end
               end
            end
         end
         DIV: begin
            rem_d  = rem_step;
            quot_d = quot_step;
            cnt_d  = cnt_q - CNTW'(1);
            if (cnt_q == '0) begin
               stack_d[top_idx] = quot_step;
               if (last_q) begin
                  state_d = RESULT;
                  if (sp_q == SP_ONE) begin
                     res_data_d = quot_step;
                  end else begin
                     res_data_d = '0;
                     err_d[3]   = 1'b1;
                  end
               end else begin
                  state_d = ACCEPT;
               end
            end
         end
         FLUSH: begin
            if (xfer && tok_last) begin
               res_data_d = '0;
               state_d    = RESULT;
            end
         end
         RESULT: begin
            if (res_ready) begin
               sp_d    = '0;
               err_d   = '0;
               state_d = ACCEPT;
            end
         end
         default: state_d = ACCEPT;
      endcase
   end

   // Control and result registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ACCEPT;
         sp_q       <= '0;
         err_q      <= '0;
         res_data_q <= '0;
         last_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         err_q      <= err_d;
         res_data_q <= res_data_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
      end
   end

   // Stack and divider datapath; contents are meaningless until written.
   always_ff @(posedge clk) begin
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      stack_q <= stack_d;
   end

endmodule

// File: tb/tb_rpn_eval_core.sv
// Testbench for rpn_eval_core: directed scenarios plus random expressions
// checked against a queue-based postfix evaluator.
module tb_rpn_eval_core;

   localparam int DATA_W      = 16;
   localparam int STACK_DEPTH = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              tok_valid;
   logic              tok_ready;
   logic              tok_is_op;
   logic [DATA_W-1:0] tok_data;
   logic              tok_last;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic [3:0]        res_err;

   int checks   = 0;
   int failures = 0;

   bit                t_op[$];
   logic [DATA_W-1:0] t_val[$];

   always #5 clk = ~clk;

   rpn_eval_core #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
      .tok_data(tok_data), .tok_last(tok_last),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_err(res_err)
   );

   task automatic clr();
      t_op.delete();
      t_val.delete();
   endtask

   task automatic num(input int v);
      t_op.push_back(1'b0);
      t_val.push_back(DATA_W'(v));
   endtask

   // Opcode in bits [1:0]; upper bits randomised since they must be ignored.
   task automatic op(input int c);
      t_op.push_back(1'b1);
      t_val.push_back(DATA_W'(($urandom & 32'hFFFC) | (c & 3)));
   endtask

   // Reference evaluator: value, error flags and the expected extra result
   // latency (DATA_W when the final token performs a real division).
   function automatic void model(output logic [DATA_W-1:0] r, output logic [3:0] e,
                                 output int lat);
      logic [DATA_W-1:0] st[$];
      logic [DATA_W-1:0] a, b;
      e = 4'b0; r = '0; lat = 0;
      for (int i = 0; i < t_op.size(); i++) begin
         if (e != 0) continue;
         if (!t_op[i]) begin
            if (st.size() == STACK_DEPTH) e = 4'b0001;
            else st.push_back(t_val[i]);
         end else if (st.size() < 2) begin
            e = 4'b0010;
         end else begin
            b = st.pop_back();
            a = st.pop_back();
            case (t_val[i][1:0])
               2'd0: st.push_back(a + b);
               2'd1: st.push_back(a - b);
               2'd2: st.push_back(a * b);
               default: begin
                  if (b == 0) e = 4'b0100;
                  else begin
                     st.push_back(a / b);
                     if (i == t_op.size() - 1) lat = DATA_W;
                  end
               end
            endcase
         end
      end
      if (e == 0) begin
         if (st.size() == 1) r = st[0];
         else e = 4'b1000;
      end
   endfunction

   // Presents all queued tokens; returns at the negedge after the last transfer.
   task automatic send_tokens(input bit gaps, output int max_wait);
      int w;
      max_wait = 0;
      for (int i = 0; i < t_op.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            tok_valid = 1'b0;
            @(negedge clk);
         end
         tok_valid = 1'b1;
         tok_is_op = t_op[i];
         tok_data  = t_val[i];
         tok_last  = (i == t_op.size() - 1);
         w = 0;
         while (!tok_ready && w < 200) begin
            @(negedge clk);
            w++;
         end
         if (!tok_ready) begin
            checks++; failures++;
            $display("FAIL tok_ready_timeout token %0d tok_ready got %b want 1", i, tok_ready);
            tok_valid = 1'b0;
            tok_last  = 1'b0;
            return;
         end
         if (w > max_wait) max_wait = w;
         @(negedge clk);
      end
      tok_valid = 1'b0;
      tok_last  = 1'b0;
   endtask

   // Waits for res_valid (bounded), samples it, optionally completes handoff.
   task automatic get_result(input bit ack, output logic [DATA_W-1:0] r,
                             output logic [3:0] e, output int lat);
      lat = 0;
      while (!res_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!res_valid) begin
         checks++; failures++;
         $display("FAIL res_valid_timeout res_valid got %b want 1", res_valid);
      end
      r = res_data;
      e = res_err;
      if (ack) begin
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = '0;
      tok_last = 1'b0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tok_ready !== 1'b0) begin failures++; $display("FAIL reset_tok_ready got %b want 0", tok_ready); end
      checks++;
      if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
      checks++;
      if (res_data !== '0 || res_err !== 4'b0) begin
         failures++; $display("FAIL reset_res got data=%0d err=%b want 0/0000", res_data, res_err);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (tok_ready !== 1'b1) begin failures++; $display("FAIL post_reset_tok_ready got %b want 1", tok_ready); end
   endtask

   task automatic test_arith();
      logic [DATA_W-1:0] r; logic [3:0] e; int lat, mw;
      clr(); num(80); num(25); op(2); num(234); op(1); num(3); num(70); op(2); op(0);
      send_tokens(1'b1, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd1976 || e !== 4'b0) begin failures++; $display("FAIL arith_1976 got %0d/%b want 1976/0000", r, e); end
      checks++;
      if (lat !== 0) begin failures++; $display("FAIL arith_latency got %0d want 0", lat); end
      clr(); num(5); num(9); op(1);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd65532 || e !== 4'b0) begin failures++; $display("FAIL sub_wrap got %0d/%b want 65532/0000", r, e); end
      clr(); num(300); num(300); op(2);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd24464 || e !== 4'b0) begin failures++; $display("FAIL mul_trunc got %0d/%b want 24464/0000", r, e); end
   endtask

   task automatic test_div();
      logic [DATA_W-1:0] r; logic [3:0] e; int lat, mw;
      clr(); num(100); num(7); op(3);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd14 || e !== 4'b0) begin failures++; $display("FAIL div_100_7 got %0d/%b want 14/0000", r, e); end
      checks++;
      if (lat !== DATA_W) begin failures++; $display("FAIL div_latency got %0d want %0d", lat, DATA_W); end
      clr(); num(100); num(7); op(3); num(0); op(0);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (mw !== DATA_W) begin failures++; $display("FAIL div_ready_low got %0d want %0d", mw, DATA_W); end
      checks++;
      if (r !== 16'd14 || e !== 4'b0) begin failures++; $display("FAIL div_then_add got %0d/%b want 14/0000", r, e); end
      clr(); num(100); num(0); op(3);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd0 || e !== 4'b0100 || lat !== 0) begin
         failures++; $display("FAIL div_zero got %0d/%b lat %0d want 0/0100 lat 0", r, e, lat);
      end
      clr(); num(65535); num(1); op(3);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd65535 || e !== 4'b0) begin failures++; $display("FAIL div_by_one got %0d/%b want 65535/0000", r, e); end
   endtask

   task automatic test_errors();
      logic [DATA_W-1:0] r; logic [3:0] e; int lat, mw;
      clr(); for (int i = 1; i <= 9; i++) num(i);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd0 || e !== 4'b0001 || lat !== 0) begin
         failures++; $display("FAIL overflow_last got %0d/%b lat %0d want 0/0001 lat 0", r, e, lat);
      end
      clr(); for (int i = 1; i <= 9; i++) num(i);
      op(0); op(0); op(3); num(0); op(3); op(0); op(0); op(0);
      send_tokens(1'b1, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd0 || e !== 4'b0001) begin failures++; $display("FAIL overflow_flush got %0d/%b want 0/0001", r, e); end
      clr(); op(0); num(4);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd0 || e !== 4'b0010) begin failures++; $display("FAIL underflow got %0d/%b want 0/0010", r, e); end
      clr(); num(3); num(4);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd0 || e !== 4'b1000) begin failures++; $display("FAIL malformed_end got %0d/%b want 0/1000", r, e); end
      clr(); num(3); op(1);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (e !== 4'b0010 || lat !== 0) begin failures++; $display("FAIL underflow_last got %b lat %0d want 0010 lat 0", e, lat); end
   endtask

   task automatic test_hold();
      logic [DATA_W-1:0] r; logic [3:0] e; int lat, mw;
      clr(); num(2); num(3); op(0);
      send_tokens(1'b0, mw); get_result(1'b0, r, e, lat);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_data !== 16'd5 || res_err !== 4'b0 || tok_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_stable cycle %0d got v=%b d=%0d e=%b rdy=%b want 1/5/0000/0",
                     k, res_valid, res_data, res_err, tok_ready);
         end
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || tok_ready !== 1'b1) begin
         failures++; $display("FAIL handoff got v=%b rdy=%b want 0/1", res_valid, tok_ready);
      end
   endtask

   task automatic test_reset_mid_div();
      logic [DATA_W-1:0] r; logic [3:0] e; int lat, mw;
      clr(); num(1000); num(3); op(3);
      send_tokens(1'b0, mw);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (tok_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== '0 || res_err !== 4'b0) begin
         failures++;
         $display("FAIL reset_mid_div got rdy=%b v=%b d=%0d e=%b want 0/0/0/0000",
                  tok_ready, res_valid, res_data, res_err);
      end
      rst = 1'b0;
      @(negedge clk);
      clr(); num(6); num(7); op(2);
      send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
      checks++;
      if (r !== 16'd42 || e !== 4'b0 || lat !== 0) begin
         failures++; $display("FAIL after_reset_expr got %0d/%b lat %0d want 42/0000 lat 0", r, e, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] r, er; logic [3:0] e, ee; int lat, el, mw;
      for (int n = 0; n < 4; n++) begin
         clr(); num(n + 10); num(n + 1); op(n);
         model(er, ee, el);
         send_tokens(1'b0, mw); get_result(1'b1, r, e, lat);
         checks++;
         if (r !== er || e !== ee || lat !== el) begin
            failures++; $display("FAIL b2b_%0d got %0d/%b lat %0d want %0d/%b lat %0d", n, r, e, lat, er, ee, el);
         end
         checks++;
         if (tok_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got %b want 1", n, tok_ready); end
      end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] r, er; logic [3:0] e, ee; int lat, el, mw, d, len;
      for (int n = 0; n < 40; n++) begin
         clr();
         len = $urandom_range(1, 14);
         if (n % 3 != 2) begin
            d = 0;
            for (int k = 0; k < len; k++) begin
               if (d < 2 || (d < STACK_DEPTH && $urandom_range(0, 1) == 1)) begin
                  num(($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 65535));
                  d++;
               end else begin
                  op($urandom_range(0, 3));
                  d--;
               end
            end
            while (d > 1) begin op($urandom_range(0, 3)); d--; end
         end else begin
            for (int k = 0; k < len; k++) begin
               if ($urandom_range(0, 2) == 0) op($urandom_range(0, 3));
               else num($urandom_range(0, 20));
            end
         end
         model(er, ee, el);
         send_tokens(1'b1, mw); get_result(1'b1, r, e, lat);
         checks++;
         if (r !== er || e !== ee || lat !== el) begin
            failures++;
            $display("FAIL random_%0d got %0d/%b lat %0d want %0d/%b lat %0d", n, r, e, lat, er, ee, el);
         end
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_div();
      test_errors();
      test_hold();
      test_reset_mid_div();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
